// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin two-port sequencer for a single-ported fixed-latency memory.
// Rev 1.0
`default_nettype none

module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0_i,
    input  logic          req1_i,
    input  logic          we0_i,
    input  logic          we1_i,
    input  logic [AW-1:0] addr0_i,
    input  logic [AW-1:0] addr1_i,
    input  logic [DW-1:0] wdata0_i,
    input  logic [DW-1:0] wdata1_i,
    output logic          gnt0_o,
    output logic          gnt1_o,
    output logic          done0_o,
    output logic          done1_o,
    output logic [DW-1:0] rdata0_o,
    output logic [DW-1:0] rdata1_o,
    output logic          mem_en_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic [DW-1:0] mem_rdata_i,
    output logic          busy_o
);

    generate
        if (MEM_LAT < 1 || MEM_LAT > 8) begin : g_bad_mem_lat
            $error("mem_port_arbiter: MEM_LAT must be within 1..8");
        end
    endgenerate

    localparam logic [2:0] CNT_INIT = 3'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    state_e        state_q;
    logic [2:0]    cnt_q;
    logic          owner_q;
    logic          we_q;
    logic          rr_last_q;
    logic          gnt0_q;
    logic          gnt1_q;
    logic          done0_q;
    logic          done1_q;
    logic          mem_en_q;
    logic          mem_we_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;
    logic [DW-1:0] rdata0_q;
    logic [DW-1:0] rdata1_q;

    // Port 1 wins when alone, or on a tie when port 0 was granted last.
    logic          any_req_d;
    logic          owner_d;
    logic          we_d;
    logic [AW-1:0] addr_d;
    logic [DW-1:0] wdata_d;

    assign any_req_d = req0_i | req1_i;
    assign owner_d   = req1_i & (~req0_i | ~rr_last_q);
    assign we_d      = owner_d ? we1_i    : we0_i;
    assign addr_d    = owner_d ? addr1_i  : addr0_i;
    assign wdata_d   = owner_d ? wdata1_i : wdata0_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 3'd0;
            owner_q     <= 1'b0;
            we_q        <= 1'b0;
            rr_last_q   <= 1'b1;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
        end else begin
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
            case (state_q)
                S_IDLE, S_RESP: begin
                    if (any_req_d) begin
                        state_q     <= S_ISSUE;
                        owner_q     <= owner_d;
                        rr_last_q   <= owner_d;
                        we_q        <= we_d;
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= we_d;
                        mem_addr_q  <= addr_d;
                        mem_wdata_q <= wdata_d;
                        gnt0_q      <= ~owner_d;
                        gnt1_q      <= owner_d;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_ISSUE: begin
                    state_q <= S_WAIT;
                    cnt_q   <= CNT_INIT;
                end
                S_WAIT: begin
                    if (cnt_q != 3'd0) begin
                        cnt_q <= cnt_q - 3'd1;
                    end else begin
                        state_q <= S_RESP;
                        done0_q <= ~owner_q;
                        done1_q <= owner_q;
                        if (!we_q) begin
                            if (owner_q) rdata1_q <= mem_rdata_i;
                            else         rdata0_q <= mem_rdata_i;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign gnt0_o      = gnt0_q;
    assign gnt1_o      = gnt1_q;
    assign done0_o     = done0_q;
    assign done1_o     = done1_q;
    assign rdata0_o    = rdata0_q;
    assign rdata1_o    = rdata1_q;
    assign mem_en_o    = mem_en_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign busy_o      = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: three lanes (MEM_LAT = 1, 3, 8), each with a latency-accurate memory and a timeline model.
// Rev 1.0
`default_nettype none

module tb_mem_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit lane_fin [3];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a == 32'h40) ? 32'h00C12283 : ((a * 32'h9E3779B1) ^ 32'h5A5A1234);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_lane
        localparam int L = (g == 0) ? 1 : ((g == 1) ? 3 : 8);

        logic        rst_n, req0, req1, we0, we1;
        logic [31:0] addr0, addr1, wdata0, wdata1;
        logic        gnt0, gnt1, done0, done1, mem_en, mem_we, busy;
        logic [31:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;

        mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(L)) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .req0_i     (req0),
            .req1_i     (req1),
            .we0_i      (we0),
            .we1_i      (we1),
            .addr0_i    (addr0),
            .addr1_i    (addr1),
            .wdata0_i   (wdata0),
            .wdata1_i   (wdata1),
            .gnt0_o     (gnt0),
            .gnt1_o     (gnt1),
            .done0_o    (done0),
            .done1_o    (done1),
            .rdata0_o   (rdata0),
            .rdata1_o   (rdata1),
            .mem_en_o   (mem_en),
            .mem_we_o   (mem_we),
            .mem_addr_o (mem_addr),
            .mem_wdata_o(mem_wdata),
            .mem_rdata_i(mem_rdata),
            .busy_o     (busy)
        );

        // Memory: read data is valid for exactly one cycle, L-1 edges after the enable edge; garbage otherwise.
        logic [31:0] envmem [logic [31:0]];
        int          pcnt = 0;
        logic [31:0] pdata = '0;
        always @(posedge clk) begin
            mem_rdata <= $urandom();
            if (pcnt > 0) begin
                if (pcnt == 1) mem_rdata <= pdata;
                pcnt--;
            end
            if (mem_en === 1'b1) begin
                if (mem_we) envmem[mem_addr] = mem_wdata;
                else begin
                    pdata = envmem.exists(mem_addr) ? envmem[mem_addr] : init_word(mem_addr);
                    if (L == 1) mem_rdata <= pdata;
                    else        pcnt = L - 1;
                end
            end
        end

        // Reference: an access sampled at edge t0 occupies cycles t0 .. t0+L+1 (ISSUE, L waits, RESP).
        logic [31:0] refmem [logic [31:0]];
        int          cyc = 0;
        int          t0  = -1;
        bit          last = 1'b1, own = 1'b0, twe = 1'b0;
        logic [31:0] tval = '0;
        logic [6:0]  e_ctl = '0;
        logic [31:0] e_maddr = '0, e_mwdata = '0, e_rd0 = '0, e_rd1 = '0;
        always @(posedge clk) begin
            if (!rst_n) begin
                last = 1'b1; t0 = -1; e_ctl = '0;
                e_maddr = '0; e_mwdata = '0; e_rd0 = '0; e_rd1 = '0;
            end else begin
                cyc++;
                if (t0 < 0 || cyc >= t0 + L + 2) begin
                    t0 = -1;
                    if (req0 || req1) begin
                        own      = (req0 && req1) ? !last : req1;
                        last     = own;
                        t0       = cyc;
                        twe      = own ? we1 : we0;
                        e_maddr  = own ? addr1 : addr0;
                        e_mwdata = own ? wdata1 : wdata0;
                        if (twe) refmem[e_maddr] = e_mwdata;
                        else tval = refmem.exists(e_maddr) ? refmem[e_maddr] : init_word(e_maddr);
                    end
                end
                e_ctl = '0;
                if (t0 >= 0) begin
                    if (cyc == t0) e_ctl = {!own, own, 2'b00, 1'b1, twe, 1'b1};
                    else if (cyc == t0 + L + 1) begin
                        e_ctl = {2'b00, !own, own, 2'b00, 1'b1};
                        if (!twe) begin
                            if (own) e_rd1 = tval;
                            else     e_rd0 = tval;
                        end
                    end else e_ctl = 7'b0000001;
                end
            end
        end

        always @(posedge clk) begin
            #2;
            check($sformatf("L%0d ctl{g0,g1,d0,d1,en,we,busy}", L), {gnt0, gnt1, done0, done1, mem_en, mem_we, busy}, e_ctl);
            check($sformatf("L%0d mem_addr", L), mem_addr, e_maddr);
            check($sformatf("L%0d mem_wdata", L), mem_wdata, e_mwdata);
            check($sformatf("L%0d rdata0", L), rdata0, e_rd0);
            check($sformatf("L%0d rdata1", L), rdata1, e_rd1);
        end

        // sel: 0 gnt0, 1 gnt1, 2 done0, 3 done1, 4 either gnt; n = negedges waited.
        task automatic wait_on(input int sel, output int n);
            n = 0;
            while (n < 300) begin
                @(negedge clk);
                n++;
                if ((sel == 0 && gnt0) || (sel == 1 && gnt1) || (sel == 2 && done0) ||
                    (sel == 3 && done1) || (sel == 4 && (gnt0 || gnt1))) return;
            end
            check($sformatf("L%0d timeout sel%0d", L, sel), 64'd0, 64'd1);
            n = -1;
        endtask

        task automatic access(input bit p, input bit w, input logic [31:0] a, input logic [31:0] d, output int lat);
            int n1, n2;
            if (p) begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; end
            else   begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
            wait_on(p ? 1 : 0, n1);
            if (p) req1 = 1'b0; else req0 = 1'b0;
            wait_on(p ? 3 : 2, n2);
            lat = n1 + n2;
        endtask

        initial begin
            int lat, n, nd;
            logic [3:0] seq;
            rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
            addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
            repeat (3) @(negedge clk);
            check($sformatf("L%0d reset ctl", L), {gnt0, gnt1, done0, done1, mem_en, mem_we, busy}, 7'd0);
            check($sformatf("L%0d reset data", L), rdata0 | rdata1 | mem_addr | mem_wdata, 32'd0);
            rst_n = 1'b1;
            @(negedge clk);

            access(1'b0, 1'b0, 32'h40, 32'h0, lat);
            check($sformatf("L%0d read latency", L), lat, L + 2);
            check($sformatf("L%0d read rdata0", L), rdata0, 32'h00C12283);
            @(negedge clk);
            check($sformatf("L%0d idle after read", L), busy, 1'b0);

            access(1'b1, 1'b1, 32'h804, 32'hDEADBEEF, lat);
            check($sformatf("L%0d write latency", L), lat, L + 2);
            check($sformatf("L%0d write keeps rdata1", L), rdata1, 32'h0);
            access(1'b1, 1'b0, 32'h804, 32'h0, lat);
            check($sformatf("L%0d readback rdata1", L), rdata1, 32'hDEADBEEF);

            req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0; addr0 = 32'h100; addr1 = 32'h104;
            seq = '0;
            for (int k = 0; k < 4; k++) begin
                wait_on(4, n);
                seq = {seq[2:0], gnt1};
                if (k > 0) check($sformatf("L%0d contention spacing", L), n, L + 2);
                addr0 = addr0 + 32'h8; addr1 = addr1 + 32'h8;
            end
            req0 = 1'b0; req1 = 1'b0;
            check($sformatf("L%0d contention order", L), seq, 4'b0101);
            wait_on(3, n);

            req0 = 1'b1; we0 = 1'b0; addr0 = 32'h0;
            for (int k = 0; k < 4; k++) begin
                wait_on(0, n);
                if (k > 0) check($sformatf("L%0d lone b2b spacing", L), n, L + 2);
                addr0 = 32'((k + 1) * 4);
                if (k == 3) req0 = 1'b0;
            end
            wait_on(2, n);

            @(negedge clk);
            req0 = 1'b1; we0 = 1'b0; addr0 = 32'h40;
            wait_on(0, n);
            req0 = 1'b0;
            @(negedge clk);
            rst_n = 1'b0;
            #1;
            check($sformatf("L%0d async reset ctl", L), {gnt0, gnt1, done0, done1, mem_en, mem_we, busy}, 7'd0);
            check($sformatf("L%0d async reset data", L), rdata0 | rdata1 | mem_addr | mem_wdata, 32'd0);
            @(negedge clk);
            rst_n = 1'b1;
            nd = 0;
            repeat (L + 4) begin
                @(negedge clk);
                if (done0) nd++;
            end
            check($sformatf("L%0d no done after reset", L), nd, 0);
            req0 = 1'b1; req1 = 1'b1; addr0 = 32'h8; addr1 = 32'hC;
            wait_on(4, n);
            check($sformatf("L%0d tie after reset", L), {gnt0, gnt1}, 2'b10);
            req0 = 1'b0; req1 = 1'b0;
            wait_on(2, n);

            fork
                begin
                    int na;
                    for (int i = 0; i < 25; i++) begin
                        repeat ($urandom_range(0, 3)) @(negedge clk);
                        req0 = 1'b1; we0 = 1'($urandom); addr0 = $urandom_range(0, 15) << 2; wdata0 = $urandom();
                        wait_on(0, na);
                        req0 = 1'b0;
                    end
                end
                begin
                    int nb;
                    for (int i = 0; i < 25; i++) begin
                        repeat ($urandom_range(0, 3)) @(negedge clk);
                        req1 = 1'b1; we1 = 1'($urandom); addr1 = $urandom_range(0, 15) << 2; wdata1 = $urandom();
                        wait_on(1, nb);
                        req1 = 1'b0;
                    end
                end
            join
            n = 0;
            while (busy && n < 100) begin
                @(negedge clk);
                n++;
            end
            check($sformatf("L%0d final idle", L), busy, 1'b0);
            lane_fin[g] = 1'b1;
        end
    end

    initial begin
        int n = 0;
        while (!(lane_fin[0] && lane_fin[1] && lane_fin[2]) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check("all lanes finished", {lane_fin[0], lane_fin[1], lane_fin[2]}, 3'b111);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter and sequencer for the single-ported unified instruction/data memory behind the multicycle RISC-V core. Port 0 carries the controller/datapath accesses (instruction fetch, lw, sw). Port 1 carries the program loader/debug requester. The block serialises accesses with round-robin fairness, drives the memory's enable/write/address/data, and waits out the memory's fixed read latency. It returns a completion pulse and captured read data to the winning requester.

## Interface
- AW, 32, address width
- DW, 32, data width
- MEM_LAT, 1, memory read latency in clock edges after the enable edge; legal range 1..8
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req0 / req1  in  1  access request, per port
- we0 / we1  in  1  1 = write, 0 = read
- addr0 / addr1  in  AW  access address
- wdata0 / wdata1  in  DW  write data
- gnt0 / gnt1  out  1  one-cycle pulse: command accepted
- done0 / done1  out  1  one-cycle pulse: access complete
- rdata0 / rdata1  out  DW  captured read data, held until the next read done on that port
- mem_en  out  1  memory enable, one cycle per access
- mem_we  out  1  memory write enable, qualified by mem_en
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid MEM_LAT-1 edges after the edge that sampled mem_en
- busy  out  1  high in every state except IDLE

## Operation
- FSM states:
  - IDLE
  - ISSUE
  - WAIT
  - RESP
- IDLE:
  - If req0 | req1 is high at the edge, pick the winner, register its we/addr/wdata, set owner, and go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE (exactly 1 cycle):
  - mem_en=1; mem_we=registered we; mem_addr and mem_wdata come from the registers.
  - gnt of the owner port = 1.
  - Next state is WAIT, with cnt=MEM_LAT-1.
- WAIT:
  - If cnt≠0, decrement cnt.
  - If cnt==0 at the edge: for a read, capture mem_rdata into the owner's rdata; go to RESP.
- RESP (exactly 1 cycle):
  - done of the owner port = 1.
  - Arbitration is sampled at the closing edge. Any pending req goes straight to ISSUE (back-to-back); otherwise go to IDLE.
- Arbitration:
  - Single requester: it wins.
  - Both requesting: the port that was not most recently granted wins (rr_last). rr_last updates on every grant.
  - rr_last resets to 1, so port 0 wins the first tie.
- Writes use the same sequence and timing as reads. A write produces done, but rdata is unchanged.
- Requester protocol:
  - Hold req, we, addr and wdata stable until gnt is seen.
  - After gnt, the requester may drop req.
  - req still high at the RESP edge is a new request.
  - Dropping req before gnt is a protocol violation. The arbiter samples only at IDLE/RESP edges; there is no other checking.
- mem_addr and mem_wdata hold their last value outside ISSUE. mem_en and mem_we are 0 outside ISSUE.
- Reset (asynchronous, any state):
  - State goes to IDLE and rr_last=1.
  - All outputs go to 0: gnt*, done*, rdata*, mem_en, mem_we, mem_addr, mem_wdata, busy.
  - An in-flight access is abandoned: no done is ever issued for it, and late mem_rdata is ignored.
- The WAIT counter is 3 bits wide. MEM_LAT outside 1..8 is a configuration error.

## Timing
- Let E0 be the edge that samples req.
- ISSUE (gnt, mem_en) is the cycle after E0.
- The memory samples mem_en at E1.
- Capture happens at E(1+MEM_LAT); done is high for the cycle after it.
- Request-to-done latency is MEM_LAT+1 edges.
- Access occupancy is MEM_LAT+2 cycles (ISSUE + MEM_LAT WAIT + RESP).
- Back-to-back throughput is one access per MEM_LAT+2 cycles; no IDLE bubble when req is pending at RESP.
- gnt and done never assert in the same cycle, and never for both ports at once.
- All outputs are registered or decoded from state only. There is no combinational path from req* to any output.

## Test plan
- **Single read** (MEM_LAT=1): memory holds 0x00C12283 at 0x40. req0=1, we0=0, addr0=0x40 at E0 → gnt0 in the cycle after E0, mem_en=1, mem_addr=0x40; done0 after E2; rdata0=0x00C12283; busy low again after E3.
- **Write then read-back:**
  - Step 1: req1 write 0x0000_0804 → wdata 0xDEADBEEF. Expect mem_we=1 during ISSUE, done1 at E0+2, rdata1 unchanged (0).
  - Step 2: req1 read 0x804 → rdata1=0xDEADBEEF.
- **Contention:** req0 and req1 held high continuously. Grants alternate gnt0, gnt1, gnt0, gnt1 (port 0 first after reset). With MEM_LAT=1, gnt pulses are spaced 3 cycles apart and there are no IDLE cycles.
- **Latency sweep:** MEM_LAT=3, req0 read at E0 → done0 at E0+4. mem_rdata driven only after E3 is captured correctly. Repeat for MEM_LAT=8 (done at E0+9).
- **Reset mid-access:** rst_n low for one cycle during WAIT of a port-0 read. All outputs are 0 immediately (asynchronously). done0 never pulses for the dropped access. The next tie after reset goes to port 0.
- **Lone requester back-to-back:** req0 held high with req1=0, four reads at addresses 0x0, 0x4, 0x8, 0xC (address changes after each gnt0). Expect four done0 pulses spaced MEM_LAT+2 cycles apart, rdata0 matching memory each time, and gnt1 never asserted.
